sram_rd_stream: RTL and testbench
=================================

// Module: sram_rd_stream
// PURPOSE
//  Read-side master for the sram_128b_w2048 macro: drives CEN/REN/A1 to fetch
//  a programmed run of consecutive words and presents them on a valid/ready
//  stream. Absorbs the macro's 1-cycle read latency and downstream
//  backpressure with a 2-entry buffer. Sits between activation/weight SRAMs and
//  the consumers that read from them. The write port (WEN/A2/D) is not driven here.
// PARAMETERS
//  DATA_W   128   word width; matches SRAM D/Q
//  ADDR_W   11    SRAM address width (2048 words)
//  LEN_W    12    transfer length width (1..2048 words)
//  FIFO_D   2     output buffer depth; fixed at 2 for full throughput
// PORTS
//  CLK        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-high
//  start      in   1       1-cycle pulse; launches a run when idle
//  base_addr  in   ADDR_W  first word address, sampled with start
//  len        in   LEN_W   word count, sampled with start
//  busy       out  1       run in progress
//  done       out  1       1-cycle pulse at end of run
//  sram_cen   out  1       SRAM chip enable, active-low
//  sram_ren   out  1       SRAM read enable, active-low
//  sram_a1    out  ADDR_W  SRAM read address
//  sram_q     in   DATA_W  SRAM read data; valid the cycle after an issue
//  out_data   out  DATA_W  stream data
//  out_valid  out  1       stream valid
//  out_ready  in   1       stream ready
// BEHAVIOUR
//  Reset: state IDLE, busy=0, done=0, sram_cen=1, sram_ren=1, sram_a1=0,
//   out_valid=0, buffer empty, in-flight flag clear. Reset mid-run aborts the run.
//  FSM: IDLE -start&len!=0-> RUN -last issue-> DRAIN -last beat popped-> IDLE.
//  start with len==0: stay IDLE, busy stays 0, done pulses the next cycle.
//  start while busy is ignored; base_addr/len are latched only in IDLE.
//  Issue rule (RUN only): issue when remaining>0 and
//   (count + inflight - pop) < 2. pop = out_valid & out_ready.
//   Issue cycle: sram_cen=0, sram_ren=0, sram_a1=cur_addr; else cen=ren=1.
//  Address: cur_addr += 1 per issue, modulo 2^ADDR_W (2047 wraps to 0).
//  Capture: the cycle after an issue, sram_q is pushed into the buffer.
//   Push and pop in the same cycle are legal; count is unchanged.
//  Stream: out_valid = buffer non-empty; out_data = head; data must stay stable
//   while valid & !ready. No beat is ever dropped or duplicated.
//  Latency: start sampled at edge E0 -> first issue in the cycle after E0 ->
//   SRAM latches at E1 -> push at E2 -> out_valid high after E2.
//  Throughput: with out_ready held high, 1 word/cycle; len words take len+2 cycles.
//  done: pulses the cycle after the final beat's handshake; busy falls in the
//   same cycle; a new start is accepted in that cycle.
// CONFIGURATION
//  SRAM_RD_STRIDE_EN defined: adds input stride[ADDR_W-1:0], sampled with start;
//   cur_addr += stride per issue (mod 2^ADDR_W); stride==0 re-reads base_addr len times.
//  Undefined: no stride port; increment fixed at 1.
// STRUCTURE
//  Package sram_rd_pkg: DATA_W/ADDR_W/LEN_W localparams, FSM state enum
//   (ST_IDLE, ST_RUN, ST_DRAIN).
//  Sub-module rd_skid_fifo: 2-entry DATA_W register FIFO with push/pop/count,
//   simultaneous push+pop allowed. Top level holds the FSM, counters and in-flight flag.
// TESTING
//  Preload mem[i]=i; base=0,len=4, ready=1 -> Q 0,1,2,3 on 4 consecutive cycles,
//   done 1 cycle after the last beat.
//  base=2046,len=4 -> A1 sequence 2046,2047,0,1; data mem[2046],mem[2047],mem[0],mem[1].
//  len=8, ready toggling 1,0,0,1,... -> all 8 words in order; out_data stable
//   while stalled; at most 2 buffered words plus 1 in flight; no extra REN.
//  len=0 start -> no CEN/REN activity, busy=0, done pulse next cycle.
//  Assert reset in DRAIN with out_valid=1 -> same cycle out_valid=0, cen=ren=1;
//   a subsequent run with base=5,len=2 returns mem[5],mem[6] only.
//  SRAM_RD_STRIDE_EN: base=10,stride=3,len=3 -> A1 10,13,16; start during busy ignored.

Source files
------------

// File: rtl/sram_rd_pkg.sv
// sram_rd_pkg: shared widths, FSM encoding and address helper for the
// SRAM read streamer (sram_rd_stream) and its output buffer (rd_skid_fifo).
package sram_rd_pkg;

    localparam int DATA_W = 128;  // word width, matches SRAM D/Q
    localparam int ADDR_W = 11;   // 2048-word macro
    localparam int LEN_W  = 12;   // run length 0..2048
    localparam int FIFO_D = 2;    // output buffer depth
    localparam int CNT_W  = $clog2(FIFO_D + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } sram_rd_state_e;

    // Next read address; the add wraps naturally at 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [ADDR_W-1:0] step);
        return addr + step;
    endfunction

endpackage

// File: rtl/rd_skid_fifo.sv
// rd_skid_fifo: 2-entry register FIFO that absorbs the SRAM read latency and
// downstream stalls. Push and pop in the same cycle are allowed; the head
// word stays put until it is popped. The producer never pushes when full.
module rd_skid_fifo
    import sram_rd_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(FIFO_D);

    logic [W-1:0]     mem [FIFO_D];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointer and occupancy bookkeeping; a simultaneous push+pop leaves count unchanged.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Data storage; contents need no reset because count gates visibility.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/sram_rd_stream.sv
// sram_rd_stream: read-side master for the 128b x 2048 SRAM macro. Fetches a
// run of len words starting at base_addr and presents them on a valid/ready
// stream through a 2-entry buffer.
//
// Stream handshake: a beat transfers on a rising CLK edge where out_valid and
// out_ready are both high; while out_valid is high and out_ready low,
// out_valid and out_data hold steady, and out_valid never depends on out_ready.
//
// Build option SRAM_RD_STRIDE_EN: adds a stride input sampled with start; the
// read address then advances by stride (mod 2048) instead of by 1.
module sram_rd_stream
    import sram_rd_pkg::*;
(
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
`ifdef SRAM_RD_STRIDE_EN
    input  logic [ADDR_W-1:0] stride,
`endif
    output logic              busy,
    output logic              done,
    output logic              sram_cen,
    output logic              sram_ren,
    output logic [ADDR_W-1:0] sram_a1,
    input  logic [DATA_W-1:0] sram_q,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output sram_rd_state_e    state_dbg
);

    sram_rd_state_e    state;
    sram_rd_state_e    state_next;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] step;
    logic [LEN_W-1:0]  remaining;
    logic              inflight;   // a read was issued last cycle; sram_q is valid now
    logic              done_r;
    logic [CNT_W-1:0]  fifo_count;
    logic [2:0]        occ;        // buffered + in flight, after this cycle's pop
    logic              accept;
    logic              issue;
    logic              pop;
    logic              last_pop;

    assign accept    = (state == ST_IDLE) && start;
    assign pop       = out_valid && out_ready;
    assign occ       = 3'(fifo_count) + 3'(inflight) - 3'(pop);
    assign issue     = (state == ST_RUN) && (remaining != '0) && (occ < 3'd2);
    // The final beat leaves only when nothing else is buffered or still returning.
    assign last_pop  = pop && (fifo_count == CNT_W'(1)) && !inflight;
    assign out_valid = (fifo_count != '0);
    assign state_dbg = state;

`ifdef SRAM_RD_STRIDE_EN
    logic [ADDR_W-1:0] stride_r;

    // Stride is part of the run descriptor and is captured with it.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            stride_r <= '0;
        end else if (accept) begin
            stride_r <= stride;
        end
    end

    assign step = stride_r;
`else
    assign step = ADDR_W'(1);
`endif

    // State register.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: a zero-length start never leaves IDLE; RUN ends on the last issue.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start && (len != '0)) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue && (remaining == LEN_W'(1))) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (last_pop) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs: SRAM strobes are asserted only in an issue cycle.
    always_comb begin
        busy     = (state != ST_IDLE);
        done     = done_r;
        sram_cen = !issue;
        sram_ren = !issue;
        sram_a1  = issue ? cur_addr : '0;
    end

    // Run descriptor, address walk, read-latency tracking and done pulse.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            cur_addr  <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            if (accept) begin
                cur_addr  <= base_addr;
                remaining <= len;
            end else if (issue) begin
                cur_addr  <= next_addr(cur_addr, step);
                remaining <= remaining - LEN_W'(1);
            end
            inflight <= issue;
            done_r   <= (accept && (len == '0)) || ((state == ST_DRAIN) && last_pop);
        end
    end

    // Output buffer: the word returned by the SRAM is captured the cycle after its issue.
    rd_skid_fifo #(
        .W(DATA_W)
    ) u_fifo (
        .CLK       (CLK),
        .reset     (reset),
        .push      (inflight),
        .push_data (sram_q),
        .pop       (pop),
        .head      (out_data),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_sram_rd_stream.sv
// tb_sram_rd_stream: directed bench for sram_rd_stream with an SRAM model
// (mem[i] = i), a scoreboard of expected addresses and beats built from each
// accepted start, and literal checks of latency, ordering and wrap-around.
// With SRAM_RD_STRIDE_EN defined the stride port and a stride run are added.
module tb_sram_rd_stream;
    import sram_rd_pkg::*;

    // ---------------- clock / reset ----------------
    logic CLK   = 1'b0;
    logic reset = 1'b1;
    always #5 CLK = ~CLK;

    logic              start     = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [LEN_W-1:0]  len       = '0;
`ifdef SRAM_RD_STRIDE_EN
    logic [ADDR_W-1:0] stride    = ADDR_W'(1);
`endif
    logic              busy;
    logic              done;
    logic              sram_cen;
    logic              sram_ren;
    logic [ADDR_W-1:0] sram_a1;
    logic [DATA_W-1:0] sram_q    = '0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    sram_rd_state_e    state_dbg;

    sram_rd_stream dut (
        .CLK       (CLK),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
`ifdef SRAM_RD_STRIDE_EN
        .stride    (stride),
`endif
        .busy      (busy),
        .done      (done),
        .sram_cen  (sram_cen),
        .sram_ren  (sram_ren),
        .sram_a1   (sram_a1),
        .sram_q    (sram_q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_dbg (state_dbg)
    );

    // ---------------- bench state ----------------
    int n_err    = 0;
    int n_checks = 0;
    int cyc      = 0;
    int start_cyc = 0;
    int done_cyc  = 0;
    int first_valid_cyc = -1;
    int ready_mode = 0;          // 0: always ready, 1: pattern 1,0,0,1, 2: never ready
    logic [3:0] pat = 4'b1001;   // pat[k] is ready in cycle k mod 4

    logic [DATA_W-1:0] mem [2048];
    logic [DATA_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] exp_a_q[$];
    logic [DATA_W-1:0] got_d[$];
    logic [ADDR_W-1:0] got_a[$];
    bit                m_busy = 1'b0;
    bit                m_done = 1'b0;
    int                outstanding = 0;
    bit                stall_prev = 1'b0;
    logic [DATA_W-1:0] stall_data = '0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ---------------- environment: cycle count, SRAM, ready ----------------
    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = DATA_W'(i);
        forever begin
            @(posedge CLK);
            cyc++;
            if (!sram_cen && !sram_ren) sram_q <= mem[sram_a1];
        end
    end

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (ready_mode == 0)      out_ready = 1'b1;
            else if (ready_mode == 1) out_ready = pat[cyc % 4];
            else                      out_ready = 1'b0;
        end
    end

    // ---------------- scoreboard / compare process ----------------
    initial begin : compare
        bit hs;
        bit busy_now;
        int step;
        logic [DATA_W-1:0] ed;
        logic [ADDR_W-1:0] ea;
        forever begin
            @(negedge CLK);
            if (reset) begin
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_valid", out_valid, 0);
                chk("rst_cen", sram_cen, 1);
                chk("rst_ren", sram_ren, 1);
                chk("rst_a1", sram_a1, 0);
                exp_q.delete();
                exp_a_q.delete();
                m_busy = 0;
                m_done = 0;
                outstanding = 0;
                stall_prev = 0;
            end else begin
                chk("busy", busy, m_busy);
                chk("done", done, m_done);
                chk("cen_eq_ren", sram_cen, sram_ren);
                if (!sram_ren) begin
                    if (exp_a_q.size() == 0) fail_now("extra_ren");
                    else begin
                        ea = exp_a_q.pop_front();
                        chk("a1", sram_a1, ea);
                    end
                    got_a.push_back(sram_a1);
                    outstanding++;
                end
                if (stall_prev) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", out_data, stall_data);
                end
                if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
                hs = out_valid && out_ready;
                if (hs) begin
                    if (exp_q.size() == 0) fail_now("extra_beat");
                    else begin
                        ed = exp_q.pop_front();
                        chk("data", out_data, ed);
                    end
                    got_d.push_back(out_data);
                    outstanding--;
                end
                chk("occupancy_le3", (outstanding <= 3), 1);
                stall_prev = out_valid && !out_ready;
                stall_data = out_data;

                // model update for the next cycle
                busy_now = m_busy;
                m_done = 0;
                if (hs && m_busy && exp_q.size() == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end
                if (start && !busy_now) begin
                    if (len == 0) m_done = 1;
                    else begin
                        m_busy = 1;
`ifdef SRAM_RD_STRIDE_EN
                        step = int'(stride);
`else
                        step = 1;
`endif
                        for (int i = 0; i < int'(len); i++) begin
                            ea = ADDR_W'((int'(base_addr) + i * step) % 2048);
                            exp_a_q.push_back(ea);
                            exp_q.push_back(mem[ea]);
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l);
        got_d.delete();
        got_a.delete();
        first_valid_cyc = -1;
        @(posedge CLK);
        #1;
        base_addr = b;
        len       = l;
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge CLK);
            if (done) begin
                seen = 1;
                done_cyc = cyc;
            end
        end
        n_checks++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
        end
        @(negedge CLK);
    endtask

    // ---------------- directed tests ----------------
    initial begin : tests
        logic [DATA_W-1:0] e_wrap [4];
        e_wrap = '{DATA_W'(2046), DATA_W'(2047), DATA_W'(0), DATA_W'(1)};

        repeat (3) @(posedge CLK);
        #1 reset = 1'b0;
        @(negedge CLK);
        chk("post_rst_state", state_dbg, ST_IDLE);
        chk("post_rst_valid", out_valid, 0);

        // T1: base 0, len 4, always ready
        ready_mode = 0;
        run(11'd0, 12'd4);
        wait_done("t1", 100);
        chk("t1_nbeats", got_d.size(), 4);
        for (int i = 0; i < got_d.size() && i < 4; i++) chk("t1_beat", got_d[i], i);
        chk("t1_first_valid_lat", first_valid_cyc - start_cyc, 3);
        chk("t1_done_lat", done_cyc - start_cyc, 7);
        chk("t1_drained", exp_q.size(), 0);

        // T2: address wrap 2046 -> 1
        run(11'd2046, 12'd4);
        wait_done("t2", 100);
        chk("t2_nissue", got_a.size(), 4);
        for (int i = 0; i < got_a.size() && i < 4; i++) chk("t2_a1", got_a[i], e_wrap[i]);
        chk("t2_nbeats", got_d.size(), 4);
        for (int i = 0; i < got_d.size() && i < 4; i++) chk("t2_beat", got_d[i], e_wrap[i]);

        // T3: len 8 with ready 1,0,0,1..., plus a start while busy
        ready_mode = 1;
        run(11'd20, 12'd8);
        repeat (2) @(posedge CLK);
        #1;
        base_addr = 11'd100;
        len       = 12'd3;
        start     = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        wait_done("t3", 200);
        chk("t3_nbeats", got_d.size(), 8);
        chk("t3_nissue", got_a.size(), 8);
        for (int i = 0; i < got_d.size() && i < 8; i++) chk("t3_beat", got_d[i], 20 + i);
        chk("t3_drained", exp_q.size(), 0);

        // T4: zero-length start
        ready_mode = 0;
        run(11'd7, 12'd0);
        wait_done("t4", 20);
        chk("t4_done_lat", done_cyc - start_cyc, 1);
        chk("t4_nissue", got_a.size(), 0);
        chk("t4_busy", busy, 0);

        // T5: reset in DRAIN with a full buffer, then a clean run
        ready_mode = 2;
        run(11'd0, 12'd2);
        repeat (6) @(posedge CLK);
        #2;
        chk("t5_state_drain", state_dbg, ST_DRAIN);
        chk("t5_valid_before", out_valid, 1);
        reset = 1'b1;
        #1;
        chk("t5_valid_async", out_valid, 0);
        chk("t5_cen_async", sram_cen, 1);
        chk("t5_ren_async", sram_ren, 1);
        chk("t5_state_async", state_dbg, ST_IDLE);
        @(posedge CLK);
        #1 reset = 1'b0;
        ready_mode = 0;
        run(11'd5, 12'd2);
        wait_done("t5", 100);
        chk("t5_nbeats", got_d.size(), 2);
        for (int i = 0; i < got_d.size() && i < 2; i++) chk("t5_beat", got_d[i], 5 + i);

`ifdef SRAM_RD_STRIDE_EN
        // T6: stride 3 from base 10
        stride = 11'd3;
        run(11'd10, 12'd3);
        wait_done("t6", 100);
        chk("t6_nissue", got_a.size(), 3);
        for (int i = 0; i < got_a.size() && i < 3; i++) chk("t6_a1", got_a[i], 10 + 3 * i);
        chk("t6_nbeats", got_d.size(), 3);
        for (int i = 0; i < got_d.size() && i < 3; i++) chk("t6_beat", got_d[i], 10 + 3 * i);
`endif

        repeat (3) @(posedge CLK);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
